bit_serial_adder: RTL and testbench

//  Sequential N-bit adder, the additive counterpart of the team's half_sub cell.

---
 rtl/bit_serial_adder_pkg.sv | 18 +
 rtl/bit_serial_adder_if.sv | 38 +++
 rtl/bit_serial_adder_full_add.sv | 24 ++
 rtl/bit_serial_adder.sv | 130 +++++++++++++
 tb/tb_bit_serial_adder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width,
// and the bit-counter sizing rule.
package bit_serial_adder_pkg;

   localparam int BSA_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The ovf signal exists only when BSA_OVERFLOW_EN is defined.
interface bit_serial_adder_if
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH_DEFAULT
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef BSA_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef BSA_OVERFLOW_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef BSA_OVERFLOW_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/bit_serial_adder_full_add.sv
// Single-bit full adder cell: two half-adder stages whose carries are ORed.
// Purely combinational.
module bit_serial_adder_full_add (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic hs1;
   logic hc1;
   logic hc2;

   assign hs1 = x ^ y;
   assign hc1 = x & y;

   assign s   = hs1 ^ ci;
   assign hc2 = hs1 & ci;

   // At most one of the two half-adder carries can be set.
   assign co  = hc1 | hc2;

endmodule

// File: rtl/bit_serial_adder.sv
// Sequential adder: one bit per clock, LSB first, through a registered carry.
// Optional signed-overflow flag when BSA_OVERFLOW_EN is defined.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = BSA_WIDTH_DEFAULT
) (
   input logic               clk,
   input logic               rst_n,
   bit_serial_adder_if.slave bus
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             cout_r;
`ifdef BSA_OVERFLOW_EN
   logic             ovf_r;
`endif

   logic             bit_s;
   logic             bit_c;
   logic             accept;
   logic             last_bit;
   logic             in_ready;
   logic             out_valid;

   bit_serial_adder_full_add u_full_add (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (bit_s),
      .co (bit_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_bit  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt == LAST) begin
               last_bit  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
`ifdef BSA_OVERFLOW_EN
         ovf_r  <= 1'b0;
`endif
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         carry  <= bus.cin;
         sum_r  <= '0;
         cnt    <= '0;
         cout_r <= 1'b0;
`ifdef BSA_OVERFLOW_EN
         ovf_r  <= 1'b0;
`endif
      end else if (state == ST_BUSY) begin
         // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
         sum_r <= WIDTH'({bit_s, sum_r} >> 1);
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         carry <= bit_c;
         cnt   <= cnt + 1'b1;
         if (last_bit) begin
            cout_r <= bit_c;
`ifdef BSA_OVERFLOW_EN
            // carry still holds the carry into the MSB on this edge.
            ovf_r  <= carry ^ bit_c;
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
`ifdef BSA_OVERFLOW_EN
   assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8); ovf is checked only
// when BSA_OVERFLOW_EN is defined.
module tb_bit_serial_adder;

   localparam int W = 8;

   typedef struct {
      string      name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic       cin;
      logic [W-1:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   always #10 clk = ~clk;

   bit_serial_adder_if #(.WIDTH(W)) bus ();

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain unsigned and signed integer arithmetic.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int total;
      total = int'(a) + int'(b) + int'(cin);
      return total[W:0];
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int total;
      total = int'($signed(a)) + int'($signed(b)) + int'(cin);
      return (total > 127) || (total < -128);
   endfunction

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("in_ready before accept", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.cin      = 1'($urandom);
   endtask

   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("in_ready after release", 32'(bus.in_ready), 32'd1);
      check("out_valid after release", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] esum, input logic ecout,
                        input logic eovf, input int hold, input logic busy_ready);
      int lat;
      bus.out_ready = busy_ready;
      start_op(a, b, cin);
      wait_done(0, lat);
      bus.out_ready = 1'b0;
      check({name, " latency"}, 32'(lat), 32'd8);
      check({name, " sum"}, 32'(bus.sum), 32'(esum));
      check({name, " cout"}, 32'(bus.cout), 32'(ecout));
`ifdef BSA_OVERFLOW_EN
      check({name, " ovf"}, 32'(bus.ovf), 32'(eovf));
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, " held out_valid"}, 32'(bus.out_valid), 32'd1);
         check({name, " held sum"}, 32'(bus.sum), 32'(esum));
         check({name, " held cout"}, 32'(bus.cout), 32'(ecout));
         check({name, " held in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      release_result();
   endtask

   initial begin
      vec_t vecs[6];
      int   lat;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   rs;

      vecs[0] = '{"basic",      8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{"ripple",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"signed_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{"cin_path",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{"neg_ovf",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{"cin_only",   8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset sum", 32'(bus.sum), 32'd0);
      check("reset cout", 32'(bus.cout), 32'd0);
`ifdef BSA_OVERFLOW_EN
      check("reset ovf", 32'(bus.ovf), 32'd0);
`endif

      foreach (vecs[i])
         do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1, 1'b0);

      // Backpressure with a stray in_valid during DONE.
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(0, lat);
      check("bp latency", 32'(lat), 32'd8);
      bus.in_valid = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", 32'(bus.out_valid), 32'd1);
         check("bp sum", 32'(bus.sum), 32'h46);
         check("bp cout", 32'(bus.cout), 32'd0);
         check("bp in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      release_result();
      @(negedge clk);
      check("bp no stray accept", 32'(bus.in_ready), 32'd1);

      // in_valid with new operands during BUSY is ignored.
      start_op(8'h35, 8'h4A, 1'b0);
      bus.in_valid = 1'b1;
      bus.a        = 8'h11;
      bus.b        = 8'h11;
      bus.cin      = 1'b1;
      check("busy in_ready", 32'(bus.in_ready), 32'd0);
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      wait_done(3, lat);
      check("busy latency", 32'(lat), 32'd8);
      check("busy sum", 32'(bus.sum), 32'h7F);
      check("busy cout", 32'(bus.cout), 32'd0);
      release_result();

      // Reset during BUSY cycle 4 aborts the operation.
      start_op(8'hA5, 8'h5A, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst busy out_valid", 32'(bus.out_valid), 32'd0);
      check("rst busy sum", 32'(bus.sum), 32'd0);
      check("rst busy cout", 32'(bus.cout), 32'd0);
      check("rst busy in_ready", 32'(bus.in_ready), 32'd1);
      repeat (10) @(negedge clk);
      check("rst busy stays idle", 32'(bus.out_valid), 32'd0);

      // Reset while a result is waiting in DONE.
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(0, lat);
      check("rst done reached", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst done out_valid", 32'(bus.out_valid), 32'd0);
      check("rst done sum", 32'(bus.sum), 32'd0);
      check("rst done cout", 32'(bus.cout), 32'd0);
      check("rst done in_ready", 32'(bus.in_ready), 32'd1);

      // Random operands, random hold time and out_ready noise during BUSY.
      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = ref_sum(ra, rb, rc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op("random", ra, rb, rc, rs[W-1:0], rs[W], ref_ovf(ra, rb, rc),
               int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
